// File: rtl/seq_shifter_if.sv
// seq_shifter_if: request/response bundle for the sequential shifter.
//   start   - request, sampled only while busy=0
//   mode    - 00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   data_in - operand
//   shamt   - shift amount
//   busy    - operation in progress
//   done    - one-cycle completion pulse
//   result  - last completed result
// master: requester side, slave: shifter side.
interface seq_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [1:0]         mode;
  logic [WIDTH-1:0]   data_in;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, mode, data_in, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, mode, data_in, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle barrel-free shifter. Shifts the captured operand
// by up to STEP bits per cycle until the captured amount is exhausted.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   bus   - seq_shifter_if slave (start/mode/data_in/shamt in,
//           busy/done/result out)
//
// state | meaning
// IDLE  | waiting for start; result holds last completed value
// SHIFT | shifting work register, counter holds remaining bits
// DONE  | done pulse cycle, result valid
module seq_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic         clk,
  input  logic         reset,
  seq_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] M_SLL  = 2'b00;
  localparam logic [1:0] M_SRL  = 2'b01;
  localparam logic [1:0] M_SRA  = 2'b10;

  // One extra bit so STEP == WIDTH is representable.
  localparam logic [SHAMT_W:0] STEP_C  = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W:0] WIDTH_C = (SHAMT_W+1)'(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   work;
  logic [SHAMT_W-1:0] cnt;
  logic [1:0]         mode_q;

  logic [SHAMT_W:0]   cnt_x;
  logic [SHAMT_W:0]   n;
  logic [SHAMT_W:0]   n_rot;
  logic [WIDTH-1:0]   shifted;

  assign cnt_x = {1'b0, cnt};
  assign n     = (cnt_x >= STEP_C) ? STEP_C : cnt_x;
  // n never exceeds WIDTH-1 here, so the left part of the rotate is a
  // shift by 1..WIDTH; a shift by WIDTH yields zero, which is what we want.
  assign n_rot = WIDTH_C - n;

  always_comb begin
    shifted = work;
    case (mode_q)
      M_SLL:   shifted = work << n;
      M_SRL:   shifted = work >> n;
      // work[WIDTH-1] still carries the original sign after every SRA step.
      M_SRA:   shifted = WIDTH'($signed(work) >>> n);
      default: shifted = (work >> n) | (work << n_rot);
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      work       <= '0;
      cnt        <= '0;
      mode_q     <= '0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            work     <= bus.data_in;
            cnt      <= bus.shamt;
            mode_q   <= bus.mode;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            work <= shifted;
            cnt  <= cnt - n[SHAMT_W-1:0];
          end else begin
            bus.result <= work;
            bus.done   <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: scoreboard bench for seq_shifter with two instances,
// STEP=1 (a) and STEP=4 (b). Stimulus pushes expected result and done
// cycle; per-instance monitors pop and compare on every done pulse and
// check that result holds between completions.
module tb_seq_shifter;

  localparam logic [1:0] SLL  = 2'b00;
  localparam logic [1:0] SRL  = 2'b01;
  localparam logic [1:0] SRA  = 2'b10;
  localparam logic [1:0] ROTR = 2'b11;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;

  seq_shifter_if #(.WIDTH(32), .SHAMT_W(5)) ia ();
  seq_shifter_if #(.WIDTH(32), .SHAMT_W(5)) ib ();

  seq_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) ua (
    .clk(clk), .reset(reset), .bus(ia.slave));
  seq_shifter #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) ub (
    .clk(clk), .reset(reset), .bus(ib.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic drive(input bit sel, input logic st, input logic [1:0] m,
                       input logic [31:0] d, input logic [4:0] s);
    if (sel) begin
      ib.start = st; ib.mode = m; ib.data_in = d; ib.shamt = s;
    end else begin
      ia.start = st; ia.mode = m; ia.data_in = d; ia.shamt = s;
    end
  endtask

  function automatic logic busy_of(input bit sel);
    return sel ? ib.busy : ia.busy;
  endfunction

  function automatic int steps(input bit sel, input logic [4:0] s);
    return sel ? (int'(s) + 3) / 4 : int'(s);
  endfunction

  task automatic wait_idle(input bit sel);
    int k = 0;
    @(negedge clk);
    while (busy_of(sel) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy_of(sel)) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_idle_timeout: dut %0d busy=1, required 0", sel);
    end
  endtask

  // Issue one operation; accepted on the next rising edge E.
  task automatic issue(input bit sel, input logic [1:0] m, input logic [31:0] d,
                       input logic [4:0] s, input logic [31:0] exp_res);
    exp_t e;
    wait_idle(sel);
    drive(sel, 1'b1, m, d, s);
    e.res = exp_res;
    e.cyc = cyc + 1 + steps(sel, s) + 1;
    if (sel) qb.push_back(e); else qa.push_back(e);
    @(negedge clk);
    chk(sel ? "b_busy_after_accept" : "a_busy_after_accept", {31'd0, busy_of(sel)}, 32'd1);
    // Scramble the inputs; the operation in flight must not notice.
    drive(sel, 1'b0, ~m, ~d, ~s);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (ia.done) begin
        if (qa.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL a_unexpected_done: got done=1 result 0x%08h, required no done", ia.result);
        end else begin
          e = qa.pop_front();
          chk("a_result", ia.result, e.res);
          chk("a_done_cycle", cyc, e.cyc);
          last_a = e.res;
        end
      end else begin
        chk("a_result_hold", ia.result, last_a);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (ib.done) begin
        if (qb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL b_unexpected_done: got done=1 result 0x%08h, required no done", ib.result);
        end else begin
          e = qb.pop_front();
          chk("b_result", ib.result, e.res);
          chk("b_done_cycle", cyc, e.cyc);
          last_b = e.res;
        end
      end else begin
        chk("b_result_hold", ib.result, last_b);
      end
    end
  end

  initial begin
    int e2;
    int k;
    drive(0, 1'b0, SLL, 32'h0, 5'd0);
    drive(1, 1'b0, SLL, 32'h0, 5'd0);
    #1 reset = 1'b1;
    #1;
    chk("reset_a_busy", {31'd0, ia.busy}, 32'd0);
    chk("reset_a_done", {31'd0, ia.done}, 32'd0);
    chk("reset_a_result", ia.result, 32'h0);
    chk("reset_b_busy", {31'd0, ib.busy}, 32'd0);
    chk("reset_b_result", ib.result, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // STEP=1 vectors
    issue(0, SLL,  32'h0000_0001, 5'd31, 32'h8000_0000);
    issue(0, SRA,  32'h8000_00F0, 5'd4,  32'hF800_000F);
    issue(0, SRL,  32'h8000_00F0, 5'd4,  32'h0800_000F);
    issue(0, ROTR, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    issue(0, SLL,  32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    issue(0, SRA,  32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    issue(0, ROTR, 32'h0000_0001, 5'd31, 32'h0000_0002);
    issue(0, SRL,  32'hFFFF_FFFF, 5'd31, 32'h0000_0001);

    // STEP=4 vectors
    issue(1, ROTR, 32'h1234_5678, 5'd10, 32'h9E04_8D15);
    issue(1, SRA,  32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    issue(1, SLL,  32'h0000_000F, 5'd7,  32'h0000_0780);
    issue(1, SRL,  32'hF000_0000, 5'd5,  32'h0780_0000);
    issue(1, SRA,  32'h7FFF_FFFF, 5'd4,  32'h07FF_FFFF);
    issue(1, ROTR, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF);
    issue(1, ROTR, 32'h0000_000F, 5'd31, 32'h0000_001E);

    // start pulses during SHIFT and during DONE are ignored
    issue(1, SLL, 32'h0000_0001, 5'd8, 32'h0000_0100);
    @(negedge clk); drive(1, 1'b1, SRA, 32'hFFFF_0000, 5'd3);
    @(negedge clk); drive(1, 1'b0, SRA, 32'hFFFF_0000, 5'd3);
    @(negedge clk); drive(1, 1'b1, SRL, 32'h1234_0000, 5'd1);
    @(negedge clk); drive(1, 1'b0, SRL, 32'h1234_0000, 5'd1);

    // start held high: re-accepted on the first edge seen in IDLE
    wait_idle(0);
    drive(0, 1'b1, SRL, 32'h0000_00F0, 5'd4);
    e2 = cyc + 1 + 4 + 3;
    qa.push_back('{res: 32'h0000_000F, cyc: cyc + 1 + 4 + 1});
    qa.push_back('{res: 32'h0000_0010, cyc: e2 + 4 + 1});
    @(negedge clk);
    drive(0, 1'b1, SRL, 32'h0000_0100, 5'd4);
    k = 0;
    while (cyc < e2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    drive(0, 1'b0, SLL, 32'hFFFF_FFFF, 5'd1);

    // reset between edges mid-SHIFT aborts, start ignored while in reset
    issue(0, SLL, 32'h0000_0003, 5'd20, 32'h0030_0000);
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    drive(0, 1'b1, SLL, 32'h0000_0001, 5'd1);
    #1;
    chk("midreset_a_busy", {31'd0, ia.busy}, 32'd0);
    chk("midreset_a_done", {31'd0, ia.done}, 32'd0);
    chk("midreset_a_result", ia.result, 32'h0);
    chk("midreset_b_result", ib.result, 32'h0);
    qa.delete();
    qb.delete();
    last_a = '0;
    last_b = '0;
    repeat (3) @(negedge clk);
    chk("inreset_a_busy", {31'd0, ia.busy}, 32'd0);
    drive(0, 1'b0, SLL, 32'h0, 5'd0);
    reset = 1'b0;
    issue(0, ROTR, 32'h1234_5678, 5'd10, 32'h9E04_8D15);

    k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: pending a=%0d b=%0d, required 0", qa.size(), qb.size());
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
